// File: rtl/mmio_responder_if.sv
// mmio_responder_if: CPU data-memory bus between the CPU (master) and the
// peripheral responder (slave).
//   address [9:0]  word address from the CPU
//   data    [31:0] write data
//   rden           read strobe
//   wren           write strobe
//   q       [31:0] registered read data from the responder
//   sel_q          q is valid and owned by the responder this cycle
interface mmio_responder_if;
    logic [9:0]  address;
    logic [31:0] data;
    logic        rden;
    logic        wren;
    logic [31:0] q;
    logic        sel_q;

    modport master (output address, data, rden, wren, input q, sel_q);
    modport slave  (input address, data, rden, wren, output q, sel_q);
endinterface

// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped peripheral responder occupying a 16-word
// window of the CPU data space. Provides control/status, a prescaled
// countdown timer with level interrupt, an LED register, a synchronized
// switch input and (optionally) a byte transmit FIFO.
//
// Ports:
//   clock     system clock
//   reset     asynchronous active-low reset
//   bus       mmio_responder_if.slave (address, data, rden, wren, q, sel_q)
//   irq       timer interrupt, level, registered
//   led[9:0]  LED register
//   sw[9:0]   raw asynchronous switches
//   tx_data   FIFO head byte
//   tx_valid  FIFO not empty
//   tx_ready  consumer accepts the head
//
// Build option: define MMIO_TX_FIFO_EN to build the TX FIFO. Without it
// tx_valid/tx_data are tied low, TXDATA writes are ignored and STATUS
// reports an empty FIFO.
module mmio_responder #(
    parameter logic [9:0]  BASE_ADDR  = 10'h3F0,
    parameter int unsigned PRESCALE   = 50,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    mmio_responder_if.slave   bus,
    output logic              irq,
    output logic [9:0]        led,
    input  logic [9:0]        sw,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h1;
    localparam logic [3:0] OFF_LOAD   = 4'h2;
    localparam logic [3:0] OFF_COUNT  = 4'h3;
    localparam logic [3:0] OFF_TXDATA = 4'h4;
    localparam logic [3:0] OFF_LED    = 4'h5;
    localparam logic [3:0] OFF_SW     = 4'h6;

    // Bus decode
    logic       hit_s, rd_s, wr_s;
    logic [3:0] off_s;
    logic       wr_ctrl_s, wr_status_s, wr_load_s, wr_txdata_s, wr_led_s;

    assign hit_s       = (bus.address[9:4] == BASE_ADDR[9:4]);
    assign off_s       = bus.address[3:0];
    assign rd_s        = hit_s & bus.rden;
    assign wr_s        = hit_s & bus.wren;
    assign wr_ctrl_s   = wr_s & (off_s == OFF_CTRL);
    assign wr_status_s = wr_s & (off_s == OFF_STATUS);
    assign wr_load_s   = wr_s & (off_s == OFF_LOAD);
    assign wr_txdata_s = wr_s & (off_s == OFF_TXDATA);
    assign wr_led_s    = wr_s & (off_s == OFF_LED);

    // Architectural state
    logic          ten_r, arl_r, ien_r, exp_r, ovf_r, irq_r;
    logic [31:0]   load_r, count_r, q_r;
    logic [PW-1:0] presc_r;
    logic [9:0]    led_r, sw_meta_r, sw_sync_r;
    logic          sel_q_r;

    // Next-state values
    logic          ten_n_s, arl_n_s, ien_n_s, exp_set_s, tick_s;
    logic [31:0]   count_n_s;
    logic [PW-1:0] presc_n_s;
    logic [31:0]   rdata_s;

    // FIFO status seen by the rest of the block
    logic [CW-1:0] fifo_cnt_s;
    logic          fifo_full_s, fifo_empty_s, ovf_set_s;

    assign tick_s = ten_r & (presc_r == PRESC_MAX);

    // Timer / control next-state; software CTRL and LOAD writes override hardware updates
    always_comb begin
        ten_n_s   = ten_r;
        arl_n_s   = arl_r;
        ien_n_s   = ien_r;
        count_n_s = count_r;
        presc_n_s = presc_r;
        exp_set_s = 1'b0;

        if (ten_r) begin
            if (presc_r == PRESC_MAX) begin
                presc_n_s = {PW{1'b0}};
            end else begin
                presc_n_s = presc_r + PW'(1'b1);
            end
        end else begin
            presc_n_s = {PW{1'b0}};
        end

        if (tick_s) begin
            if (count_r != 32'd0) begin
                count_n_s = count_r - 32'd1;
            end else begin
                exp_set_s = 1'b1;
                if (arl_r) begin
                    count_n_s = load_r;
                end else begin
                    ten_n_s   = 1'b0;
                    count_n_s = 32'd0;
                end
            end
        end else begin
            count_n_s = count_r;
        end

        if (wr_ctrl_s) begin
            ten_n_s = bus.data[0];
            arl_n_s = bus.data[1];
            ien_n_s = bus.data[2];
        end else begin
            ien_n_s = ien_r;
        end

        if (wr_load_s) begin
            count_n_s = bus.data;
            presc_n_s = {PW{1'b0}};
        end else begin
            presc_n_s = presc_n_s;
        end
    end

    // Read data mux (values before any same-cycle write)
    always_comb begin
        rdata_s = 32'd0;
        case (off_s)
            OFF_CTRL:   rdata_s = {29'd0, ien_r, arl_r, ten_r};
            OFF_STATUS: rdata_s = {19'd0, 5'(fifo_cnt_s), 4'd0,
                                   ovf_r, fifo_empty_s, fifo_full_s, exp_r};
            OFF_LOAD:   rdata_s = load_r;
            OFF_COUNT:  rdata_s = count_r;
            OFF_LED:    rdata_s = {22'd0, led_r};
            OFF_SW:     rdata_s = {22'd0, sw_sync_r};
            default:    rdata_s = 32'd0;
        endcase
    end

    // Control, timer, sticky status, LED and read-return registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ten_r   <= 1'b0;
            arl_r   <= 1'b0;
            ien_r   <= 1'b0;
            load_r  <= 32'd0;
            count_r <= 32'd0;
            presc_r <= {PW{1'b0}};
            exp_r   <= 1'b0;
            ovf_r   <= 1'b0;
            irq_r   <= 1'b0;
            led_r   <= 10'd0;
            q_r     <= 32'd0;
            sel_q_r <= 1'b0;
        end else begin
            ten_r   <= ten_n_s;
            arl_r   <= arl_n_s;
            ien_r   <= ien_n_s;
            count_r <= count_n_s;
            presc_r <= presc_n_s;
            if (wr_load_s) begin
                load_r <= bus.data;
            end else begin
                load_r <= load_r;
            end
            // Hardware set has priority over write-1-clear
            exp_r   <= (exp_r & ~(wr_status_s & bus.data[0])) | exp_set_s;
            ovf_r   <= (ovf_r & ~(wr_status_s & bus.data[3])) | ovf_set_s;
            irq_r   <= exp_r & ien_r;
            if (wr_led_s) begin
                led_r <= bus.data[9:0];
            end else begin
                led_r <= led_r;
            end
            sel_q_r <= rd_s;
            // A simultaneous write turns the read into a zero-data acknowledge
            q_r     <= (rd_s & ~bus.wren) ? rdata_s : 32'd0;
        end
    end

    // Two-flop synchronizer for the asynchronous switches
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_meta_r <= 10'd0;
            sw_sync_r <= 10'd0;
        end else begin
            sw_meta_r <= sw;
            sw_sync_r <= sw_meta_r;
        end
    end

`ifdef MMIO_TX_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r, rd_ptr_n_s;
    logic [CW-1:0] cnt_r, cnt_n_s;
    logic          push_s, pop_s, tx_valid_r;
    logic [7:0]    tx_data_r, head_n_s;

    assign fifo_cnt_s   = cnt_r;
    assign fifo_full_s  = (cnt_r == FULL_CNT);
    assign fifo_empty_s = (cnt_r == {CW{1'b0}});
    assign pop_s        = ~fifo_empty_s & tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_s       = wr_txdata_s & (~fifo_full_s | pop_s);
    assign ovf_set_s    = wr_txdata_s & fifo_full_s & ~pop_s;
    assign rd_ptr_n_s   = pop_s ? (rd_ptr_r + AW'(1'b1)) : rd_ptr_r;
    assign cnt_n_s      = cnt_r + CW'(push_s) - CW'(pop_s);

    // Next head byte, bypassing the array when the new head is the byte being pushed
    always_comb begin
        head_n_s = mem_r[rd_ptr_n_s];
        if (push_s && (wr_ptr_r == rd_ptr_n_s)) begin
            head_n_s = bus.data[7:0];
        end else begin
            head_n_s = mem_r[rd_ptr_n_s];
        end
    end

    // FIFO storage, pointers, occupancy and registered head outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_r[i] <= 8'd0;
            end
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= bus.data[7:0];
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            rd_ptr_r   <= rd_ptr_n_s;
            cnt_r      <= cnt_n_s;
            tx_valid_r <= (cnt_n_s != {CW{1'b0}});
            tx_data_r  <= (cnt_n_s != {CW{1'b0}}) ? head_n_s : 8'd0;
        end
    end

    assign tx_valid = tx_valid_r;
    assign tx_data  = tx_data_r;
`else
    logic unused_fifo_s;

    assign fifo_cnt_s    = {CW{1'b0}};
    assign fifo_full_s   = 1'b0;
    assign fifo_empty_s  = 1'b1;
    assign ovf_set_s     = 1'b0;
    assign unused_fifo_s = tx_ready & wr_txdata_s;
    assign tx_valid      = 1'b0;
    assign tx_data       = 8'd0;
`endif

    assign bus.q     = q_r;
    assign bus.sel_q = sel_q_r;
    assign irq       = irq_r;
    assign led       = led_r;

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: self-checking bench for mmio_responder (PRESCALE=2,
// FIFO_DEPTH=8). Reads push their expected data into a scoreboard queue; a
// negedge monitor pops and compares whenever sel_q is seen. FIFO bytes are
// tracked with a small reference queue.
module tb_mmio_responder;

    logic       clock;
    logic       reset;
    logic       irq;
    logic [9:0] led;
    logic [9:0] sw;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    mmio_responder_if bus_if ();

    mmio_responder #(
        .BASE_ADDR  (10'h3F0),
        .PRESCALE   (2),
        .FIFO_DEPTH (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus_if),
        .irq      (irq),
        .led      (led),
        .sw       (sw),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic [7:0]  txq   [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Comparison helper shared by every check
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [9:0] ra(input logic [3:0] off);
        return {6'h3F, off};
    endfunction

    // Read: expectation is queued only when the address is inside the window
    task automatic rd(input logic [9:0] a, input logic [31:0] want, input string tag);
        bus_if.address = a;
        bus_if.rden    = 1'b1;
        if (a[9:4] == 6'h3F) begin
            exp_q.push_back(want);
            tag_q.push_back(tag);
        end
        @(posedge clock); #1;
        bus_if.rden = 1'b0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        bus_if.address = a;
        bus_if.data    = d;
        bus_if.wren    = 1'b1;
        @(posedge clock); #1;
        bus_if.wren = 1'b0;
    endtask

    // Push to TXDATA while the reference model tracks what the FIFO should hold
    task automatic push(input logic [7:0] b);
        if (txq.size() < 8) begin
            txq.push_back(b);
        end else if (tx_ready) begin
            void'(txq.pop_front());
            txq.push_back(b);
        end
        wr(ra(4'h4), {24'hABCDEF, b});
    endtask

    // Scoreboard monitor, sampling away from the active edge
    always @(negedge clock) begin
        if (reset) begin
            if (bus_if.sel_q) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_sel_q", 32'd1, 32'd0);
                end else begin
                    check_eq(tag_q.pop_front(), bus_if.q, exp_q.pop_front());
                end
            end else if (bus_if.q !== 32'd0) begin
                check_eq("q_idle_zero", bus_if.q, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b0;
        bus_if.address = 10'd0;
        bus_if.data    = 32'd0;
        bus_if.rden    = 1'b0;
        bus_if.wren    = 1'b0;
        sw             = 10'd0;
        tx_ready       = 1'b0;
        #12;
        check_eq("rst_q",        bus_if.q, 32'd0);
        check_eq("rst_sel_q",    {31'd0, bus_if.sel_q}, 32'd0);
        check_eq("rst_irq",      {31'd0, irq}, 32'd0);
        check_eq("rst_led",      {22'd0, led}, 32'd0);
        check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("rst_tx_data",  {24'd0, tx_data}, 32'd0);
        #10 reset = 1'b1;
        @(posedge clock); #1;

        rd(ra(4'h0), 32'd0, "rst_ctrl");
        rd(ra(4'h1), 32'h4, "rst_status");

        // LED round trip, upper data bits masked
        wr(ra(4'h5), 32'hFFFF_F2A5);
        check_eq("led_out", {22'd0, led}, 32'h2A5);
        rd(ra(4'h5), 32'h2A5, "led_read");
        wr(ra(4'h0), 32'hFFFF_FFF8);
        rd(ra(4'h0), 32'd0, "ctrl_mask");
        rd(ra(4'h9), 32'd0, "unmapped_read");
        rd(ra(4'h4), 32'd0, "txdata_read");

        // Out-of-window read
        rd(10'h100, 32'd0, "miss");
        check_eq("miss_sel_q", {31'd0, bus_if.sel_q}, 32'd0);
        check_eq("miss_q", bus_if.q, 32'd0);

        // Read and write together: write wins, q returns 0 with sel_q
        bus_if.data = 32'h155;
        bus_if.wren = 1'b1;
        rd(ra(4'h5), 32'd0, "rw_collision");
        bus_if.wren = 1'b0;
        check_eq("rw_led", {22'd0, led}, 32'h155);

        // Switch synchronizer latency
        sw = 10'h3FF;
        rd(ra(4'h6), 32'd0, "sw_lat1");
        rd(ra(4'h6), 32'd0, "sw_lat2");
        rd(ra(4'h6), 32'h3FF, "sw_sync");

        // One-shot timer: LOAD=3, TEN|IEN
        wr(ra(4'h2), 32'd3);
        wr(ra(4'h0), 32'h5);
        repeat (7) @(posedge clock);
        #1;
        check_eq("oneshot_irq_early", {31'd0, irq}, 32'd0);
        rd(ra(4'h1), 32'h4, "oneshot_before_exp");
        check_eq("oneshot_irq_lag", {31'd0, irq}, 32'd0);
        rd(ra(4'h1), 32'h5, "oneshot_exp");
        check_eq("oneshot_irq", {31'd0, irq}, 32'd1);
        rd(ra(4'h0), 32'h4, "oneshot_ten_clear");
        wr(ra(4'h1), 32'h1);
        check_eq("irq_hold", {31'd0, irq}, 32'd1);
        @(posedge clock); #1;
        check_eq("irq_drop", {31'd0, irq}, 32'd0);
        rd(ra(4'h3), 32'd0, "oneshot_count");
        wr(ra(4'h0), 32'd0);

        // Auto-reload: LOAD=1, TEN|ARL
        wr(ra(4'h2), 32'd1);
        wr(ra(4'h0), 32'h3);
        repeat (4) @(posedge clock);
        #1;
        wr(ra(4'h1), 32'h1);
        rd(ra(4'h1), 32'h4, "arl_cleared");
        @(posedge clock); #1;
        wr(ra(4'h1), 32'h1);
        rd(ra(4'h1), 32'h5, "arl_set_wins");
        rd(ra(4'h3), 32'd1, "arl_reload");
        check_eq("arl_no_irq", {31'd0, irq}, 32'd0);
        wr(ra(4'h0), 32'd0);
        wr(ra(4'h1), 32'h1);
        rd(ra(4'h1), 32'h4, "arl_stopped");

`ifdef MMIO_TX_FIFO_EN
        // Overflow: 9 pushes into depth 8 with no consumer
        check_eq("fifo_idle_valid", {31'd0, tx_valid}, 32'd0);
        for (int i = 0; i < 9; i++) begin
            push(8'h10 + 8'(i));
            if (i == 0) begin
                check_eq("fifo_first_valid", {31'd0, tx_valid}, 32'd1);
                check_eq("fifo_first_data", {24'd0, tx_data}, 32'h10);
            end
        end
        rd(ra(4'h1), 32'h80A, "fifo_full_ovf");
        wr(ra(4'h1), 32'h8);
        check_eq("fifo_head_hold", {24'd0, tx_data}, 32'h10);
        // Push and pop together while full
        tx_ready = 1'b1;
        push(8'h19);
        tx_ready = 1'b0;
        check_eq("fifo_collision_head", {24'd0, tx_data}, 32'h11);
        rd(ra(4'h1), 32'h802, "fifo_collision_status");
        // Drain in order
        tx_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (tx_valid && (txq.size() != 0)) begin
                check_eq("fifo_drain", {24'd0, tx_data}, {24'd0, txq.pop_front()});
                @(posedge clock); #1;
            end
        end
        tx_ready = 1'b0;
        check_eq("fifo_drain_left", txq.size(), 32'd0);
        check_eq("fifo_drained_valid", {31'd0, tx_valid}, 32'd0);
        rd(ra(4'h1), 32'h4, "fifo_empty_status");
`else
        // No FIFO built: pushes are ignored
        tx_ready = 1'b1;
        wr(ra(4'h4), 32'hAB);
        wr(ra(4'h4), 32'hCD);
        check_eq("nofifo_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("nofifo_data", {24'd0, tx_data}, 32'd0);
        tx_ready = 1'b0;
        wr(ra(4'h4), 32'hEF);
        rd(ra(4'h1), 32'h4, "nofifo_status");
`endif

        // Asynchronous reset mid-count with data in flight
        wr(ra(4'h2), 32'd100);
        wr(ra(4'h0), 32'h1);
`ifdef MMIO_TX_FIFO_EN
        txq.delete();
        for (int i = 0; i < 4; i++) begin
            push(8'h40 + 8'(i));
        end
`endif
        wr(ra(4'h5), 32'h3C3);
        rd(ra(4'h5), 32'h3C3, "pre_reset_led");
        #1 reset = 1'b0;
        exp_q.delete();
        tag_q.delete();
        txq.delete();
        #1;
        check_eq("arst_q",        bus_if.q, 32'd0);
        check_eq("arst_sel_q",    {31'd0, bus_if.sel_q}, 32'd0);
        check_eq("arst_irq",      {31'd0, irq}, 32'd0);
        check_eq("arst_led",      {22'd0, led}, 32'd0);
        check_eq("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("arst_tx_data",  {24'd0, tx_data}, 32'd0);
        #4 reset = 1'b1;
        @(posedge clock); #1;
        rd(ra(4'h3), 32'd0, "post_rst_count");
        rd(ra(4'h1), 32'h4, "post_rst_status");
        rd(ra(4'h0), 32'd0, "post_rst_ctrl");
        rd(ra(4'h2), 32'd0, "post_rst_load");
        check_eq("post_rst_tx_valid", {31'd0, tx_valid}, 32'd0);

        repeat (3) @(posedge clock);
        #1;
        check_eq("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
